psx_pad_responder: RTL

Protocol sequencer on the PPB side of the PSX device port: consumes received command bytes, schedules each outgoing reply byte and requests the per-byte ACK. It emulates a standard digital pad answering the 0x42 poll. It sits between the device-port adapter (serial↔PPB) and the button source (board inputs or host link). All packet state is cleared whenever the host deselects the device.

---
 rtl/psx_pkg.sv | 20 ++
 rtl/psx_pad_responder_if.sv | 22 ++
 rtl/psx_pad_responder.sv | 85 ++++++++
 3 files changed

// File: rtl/psx_pkg.sv
// Shared PSX device-port constants and the responder state encoding.
// Reused by the pad responder and the memory-card responder.
package psx_pkg;

    localparam logic [7:0] PSX_ADDR_PAD   = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_TAP        = 8'h5A;
    localparam logic [7:0] PSX_IDLE_REPLY = 8'hFF;

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_CMD,
        ST_TAP,
        ST_DATA0,
        ST_DATA1,
        ST_IGNORE
    } psx_resp_state_t;

endpackage

// File: rtl/psx_pad_responder_if.sv
// PPB-side byte bus between the device-port adapter and a responder, plus pad inputs and poll pulse.
interface psx_pad_responder_if;

    logic [7:0]  PPB_command;
    logic        PPB_command_strobe;
    logic [7:0]  PPB_reply;
    logic        PPB_ack_strobe;
    logic        pad_enable;
    logic [15:0] buttons;
    logic        poll_strobe;

    modport master (
        output PPB_command, PPB_command_strobe, pad_enable, buttons,
        input  PPB_reply, PPB_ack_strobe, poll_strobe
    );

    modport slave (
        input  PPB_command, PPB_command_strobe, pad_enable, buttons,
        output PPB_reply, PPB_ack_strobe, poll_strobe
    );

endinterface

// File: rtl/psx_pad_responder.sv
// Digital pad answering the 0x42 poll: one transition per command strobe, no backpressure.
// Reply, ack and poll pulses are registered and appear 1 clk after the strobe.
module psx_pad_responder
    import psx_pkg::*;
#(
    parameter logic [7:0] PAD_ADDRESS = PSX_ADDR_PAD,
    parameter logic [7:0] PAD_ID      = PSX_ID_DIGITAL
) (
    input  logic                  clk,
    input  logic                  PPB_packet_reset,
    psx_pad_responder_if.slave    ppb
);

    psx_resp_state_t st, st_nxt;
    logic [7:0]      reply, reply_nxt;
    logic            ack, ack_nxt;
    logic            poll, poll_nxt;
    logic [15:0]     snapshot, snapshot_nxt;

    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            st       <= ST_ADDR;
            reply    <= PSX_IDLE_REPLY;
            ack      <= 1'b0;
            poll     <= 1'b0;
            snapshot <= 16'hFFFF;
        end else begin
            st       <= st_nxt;
            reply    <= reply_nxt;
            ack      <= ack_nxt;
            poll     <= poll_nxt;
            snapshot <= snapshot_nxt;
        end
    end

    // ack/poll are pulses: they drop back to 0 on any cycle without a strobe.
    always_comb begin
        st_nxt       = st;
        reply_nxt    = reply;
        ack_nxt      = 1'b0;
        poll_nxt     = 1'b0;
        snapshot_nxt = snapshot;
        if (ppb.PPB_command_strobe) begin
            reply_nxt = PSX_IDLE_REPLY;
            st_nxt    = ST_IGNORE;
            case (st)
                ST_ADDR: begin
                    if (ppb.PPB_command == PAD_ADDRESS && ppb.pad_enable) begin
                        reply_nxt = PAD_ID;
                        ack_nxt   = 1'b1;
                        st_nxt    = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (ppb.PPB_command == PSX_CMD_POLL) begin
                        reply_nxt    = PSX_TAP;
                        ack_nxt      = 1'b1;
                        snapshot_nxt = ppb.buttons;
                        st_nxt       = ST_TAP;
                    end
                end
                ST_TAP: begin
                    reply_nxt = snapshot[7:0];
                    ack_nxt   = 1'b1;
                    st_nxt    = ST_DATA0;
                end
                ST_DATA0: begin
                    reply_nxt = snapshot[15:8];
                    ack_nxt   = 1'b1;
                    st_nxt    = ST_DATA1;
                end
                ST_DATA1: begin
                    // The final byte of a packet is never acknowledged.
                    poll_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ppb.PPB_reply      = reply;
    assign ppb.PPB_ack_strobe = ack;
    assign ppb.poll_strobe    = poll;

endmodule
